tdm_demux_8: RTL and testbench
==============================

TDM_DEMUX_8 -- requirements
Module: tdm_demux_8

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: din  in  1  serial TDM data bit.
REQ-004 SHALL have ports: din_valid  in  1  din is sampled this cycle.
REQ-005 SHALL have ports: sync  in  1  frame marker, qualified by din_valid; marks slot 0.
REQ-006 SHALL have ports: dout  out  8  last complete frame, bit k = slot k.
REQ-007 SHALL have ports: dout_valid  out  1  one-cycle pulse when dout updates.
REQ-008 SHALL have ports: slot  out  4  index of the next slot to be written.
REQ-009 SHALL have ports: sync_err  out  1  one-cycle pulse on an early or misplaced sync.
REQ-010 SHALL have ports: par_err  out  1  one-cycle pulse with dout_valid on a parity mismatch; 0 when parity is compiled out.

Function
REQ-011 SHALL implement a two-state FSM.
- HUNT: discard samples until a din_valid&sync sample arrives.
- RUN: capture samples into the frame.
REQ-012 SHALL, in HUNT on din_valid&sync:
- write din to shadow[0];
- set slot=1;
- go to RUN.
REQ-013 SHALL, in HUNT on din_valid without sync, ignore the sample and hold slot=0.
REQ-014 SHALL, in RUN on din_valid with sync=0, write din to shadow[slot] and increment slot.
REQ-015 SHALL, in RUN on din_valid&sync with slot==0, treat the sample as a normal slot-0 write.
REQ-016 SHALL, in RUN on din_valid&sync with slot!=0:
- pulse sync_err next cycle;
- discard the partial frame (no dout_valid);
- write din to shadow[0];
- set slot=1.
REQ-017 SHALL, in RUN on din_valid with sync=0 and slot==0, keep capturing; this is not an error.
REQ-018 SHALL, on the last data slot (slot 7), load dout with {din, shadow[6:0]} on the same edge and pulse dout_valid for exactly that next cycle.
- Latency: 1 clock from the final valid sample.
REQ-019 SHALL wrap slot to 0 after the last slot of the frame.
REQ-020 SHALL hold all state while din_valid=0; gaps of any length are legal mid-frame.
REQ-021 SHALL hold dout stable between dout_valid pulses.
REQ-022 SHALL give sync_err priority over frame completion when both apply in the same sample.

Reset
REQ-023 SHALL, on rst=1 at any time including mid-frame:
- set FSM=HUNT, slot=0;
- set shadow=0, dout=8'h00;
- set dout_valid=0, sync_err=0, par_err=0.
REQ-024 SHALL release from reset into HUNT, requiring a fresh sync.

Configuration
REQ-025 SHALL compile a parity slot in only when TDM_DEMUX_PARITY_EN is defined.
- Frame length becomes 9 slots; slot 8 carries even parity over slots 0-7.
- dout and dout_valid move to slot 8 (REQ-018 applies to slot 8 instead of slot 7).
- par_err pulses alongside dout_valid on a mismatch; dout is still updated.
REQ-026 SHALL, without TDM_DEMUX_PARITY_EN:
- use an 8-slot frame;
- tie par_err to 0;
- never let slot exceed 7.

Structure
REQ-027 SHALL place in package tdm_demux_pkg:
- NUM_DATA_SLOTS=8, SLOT_W=4;
- the FSM state enum {HUNT, RUN}.
REQ-028 SHALL use one sub-module, dec_3x8, a one-hot write-enable decoder from slot[2:0] gated by din_valid, to drive the shadow register.

Verification
REQ-029 SHALL cover: sync with bits 1,0,1,1,0,0,1,0 on consecutive cycles -> dout=8'h4D and one dout_valid pulse 1 cycle after the 8th sample.
REQ-030 SHALL cover: the same frame with din_valid=0 for 3 cycles between slots 3 and 4 -> same dout=8'h4D, slot held at 4 during the gap.
REQ-031 SHALL cover: sync at slot 5 of a frame -> sync_err pulse, no dout_valid; the next 8 samples -> dout updated from the new frame only.
REQ-032 SHALL cover: 10 valid samples with no sync after reset -> slot stays 0, no dout_valid.
REQ-033 SHALL cover: rst asserted at slot 6 -> all outputs 0 immediately; the next frame needs sync.
REQ-034 SHALL cover, with TDM_DEMUX_PARITY_EN: data 8'h4D with parity bit 1 -> par_err=1; with parity bit 0 -> par_err=0. Both cases dout=8'h4D.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared constants and FSM state type for the 8-slot TDM demultiplexer.
// Frame length grows to 9 slots (trailing even-parity slot) when TDM_DEMUX_PARITY_EN is defined.
package tdm_demux_pkg;

  localparam int unsigned NUM_DATA_SLOTS = 8;
  localparam int unsigned SLOT_W         = 4;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int unsigned FRAME_SLOTS = NUM_DATA_SLOTS + 1;
`else
  localparam int unsigned FRAME_SLOTS = NUM_DATA_SLOTS;
`endif

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_SLOTS - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux_8_if.sv
// Serial TDM input and demultiplexed frame output bundle.
interface tdm_demux_8_if;
  import tdm_demux_pkg::*;

  logic              din;
  logic              din_valid;
  logic              sync;
  logic [7:0]        dout;
  logic              dout_valid;
  logic [SLOT_W-1:0] slot;
  logic              sync_err;
  logic              par_err;

  modport master (
    output din, din_valid, sync,
    input  dout, dout_valid, slot, sync_err, par_err
  );

  modport slave (
    input  din, din_valid, sync,
    output dout, dout_valid, slot, sync_err, par_err
  );
endinterface

// File: rtl/tdm_demux_8_dec_3x8.sv
// One-hot shadow-register write-enable decoder.
module dec_3x8 (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] we
);
  always_comb begin
    we = '0;
    if (en) we[sel] = 1'b1;
  end
endmodule

// File: rtl/tdm_demux_8.sv
// Serial TDM frame demultiplexer: sync-aligned capture of 8 slots into a parallel word.
// Define TDM_DEMUX_PARITY_EN to add a 9th even-parity slot and enable par_err.
module tdm_demux_8
  import tdm_demux_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  tdm_demux_8_if.slave bus
);

  state_t            state, state_nxt;
  logic [SLOT_W-1:0] slot_q, slot_nxt;
  logic [7:0]        shadow, we, frame, dout_q;
  logic              restart, capture, complete;
  logic              dout_valid_q, sync_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= HUNT;
      slot_q <= '0;
    end else begin
      state  <= state_nxt;
      slot_q <= slot_nxt;
    end
  end

  // A misplaced sync restarts the frame and suppresses completion in the same sample.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot_q;
    restart   = 1'b0;
    capture   = 1'b0;
    complete  = 1'b0;
    if (bus.din_valid) begin
      unique case (state)
        HUNT: begin
          if (bus.sync) begin
            state_nxt = RUN;
            slot_nxt  = SLOT_W'(1);
            capture   = 1'b1;
          end
        end
        RUN: begin
          capture = 1'b1;
          if (bus.sync && (slot_q != '0)) begin
            restart  = 1'b1;
            slot_nxt = SLOT_W'(1);
          end else if (slot_q == LAST_SLOT) begin
            complete = 1'b1;
            slot_nxt = '0;
          end else begin
            slot_nxt = slot_q + SLOT_W'(1);
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // The parity slot (slot 8) has slot[3] set and must not alias onto shadow[0].
  dec_3x8 u_dec (
    .sel (restart ? 3'd0 : slot_q[2:0]),
    .en  (bus.din_valid && capture && (restart || !slot_q[SLOT_W-1])),
    .we  (we)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_DATA_SLOTS; k++)
        if (we[k]) shadow[k] <= bus.din;
    end
  end

  // Bypass the bit being written this cycle so the final slot lands in dout on the same edge.
  assign frame = (shadow & ~we) | ({8{bus.din}} & we);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      dout_valid_q <= complete;
      sync_err_q   <= restart;
      if (complete) dout_q <= frame;
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_err_q <= 1'b0;
    else     par_err_q <= complete && (^{shadow, bus.din});
  end

  assign bus.par_err = par_err_q;
`else
  assign bus.par_err = 1'b0;
`endif

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.slot       = slot_q;
  assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_8.sv
// Randomized and directed bench for tdm_demux_8 against a queue-based frame model.
module tb_tdm_demux_8;
  import tdm_demux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tdm_demux_8_if bus ();

  tdm_demux_8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: a frame is the list of bits collected since the last sync.
  bit         locked;
  bit         q[$];
  logic [7:0] e_dout;
  logic       e_dv, e_serr, e_perr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    locked = 1'b0;
    q.delete();
    e_dout = '0;
    e_dv   = 1'b0;
    e_serr = 1'b0;
    e_perr = 1'b0;
  endtask

  task automatic model_sample(input bit d, input bit v, input bit s);
    int ones;
    e_dv   = 1'b0;
    e_serr = 1'b0;
    e_perr = 1'b0;
    if (v) begin
      if (!locked) begin
        if (s) begin
          locked = 1'b1;
          q = {d};
        end
      end else if (s && q.size() != 0) begin
        e_serr = 1'b1;
        q = {d};
      end else begin
        q.push_back(d);
        if (q.size() == FRAME) begin
          for (int k = 0; k < 8; k++) e_dout[k] = q[k];
          e_dv = 1'b1;
          ones = 0;
          foreach (q[i]) ones += int'(q[i]);
          e_perr = (FRAME == 9) && (ones % 2 != 0);
          q.delete();
        end
      end
    end
  endtask

  task automatic check_all(input string pfx);
    check({pfx, "_dout"},     32'(bus.dout),       32'(e_dout));
    check({pfx, "_dvalid"},   32'(bus.dout_valid), 32'(e_dv));
    check({pfx, "_slot"},     32'(bus.slot),       32'(q.size()));
    check({pfx, "_sync_err"}, 32'(bus.sync_err),   32'(e_serr));
    check({pfx, "_par_err"},  32'(bus.par_err),    32'(e_perr));
  endtask

  task automatic step(input bit d, input bit v, input bit s);
    @(negedge clk);
    bus.din       = d;
    bus.din_valid = v;
    bus.sync      = s;
    @(posedge clk);
    #1;
    model_sample(d, v, s);
    check_all("step");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.sync      = 1'b0;
    #1;
    model_reset();
    check("rst_dout",     32'(bus.dout),       32'h0);
    check("rst_dvalid",   32'(bus.dout_valid), 32'h0);
    check("rst_slot",     32'(bus.slot),       32'h0);
    check("rst_sync_err", 32'(bus.sync_err),   32'h0);
    check("rst_par_err",  32'(bus.par_err),    32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input bit par, input bit with_sync);
    for (int k = 0; k < 8; k++) step(data[k], 1'b1, with_sync && (k == 0));
    if (FRAME == 9) step(par, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] nd;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.sync      = 1'b0;
    model_reset();
    do_reset();

    // Basic frame: 1,0,1,1,0,0,1,0 -> 8'h4D with one dout_valid pulse.
    send_frame(8'h4D, 1'b0, 1'b1);
    check("basic_dout",   32'(bus.dout),       32'h4D);
    check("basic_dvalid", 32'(bus.dout_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    check("basic_pulse_end", 32'(bus.dout_valid), 32'h0);

    // Same frame with a 3-cycle gap between slots 3 and 4.
    nd = 8'h4D;
    for (int k = 0; k < 4; k++) step(nd[k], 1'b1, k == 0);
    for (int g = 0; g < 3; g++) begin
      step(1'b1, 1'b0, 1'b1);
      check("gap_slot", 32'(bus.slot), 32'h4);
    end
    for (int k = 4; k < 8; k++) step(nd[k], 1'b1, 1'b0);
    if (FRAME == 9) step(1'b0, 1'b1, 1'b0);
    check("gap_dout", 32'(bus.dout), 32'h4D);

    // Misplaced sync at slot 5 restarts the frame.
    nd = 8'hA5;
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, k == 0);
    step(nd[0], 1'b1, 1'b1);
    check("serr_pulse",  32'(bus.sync_err),   32'h1);
    check("serr_no_dv",  32'(bus.dout_valid), 32'h0);
    for (int k = 1; k < 8; k++) step(nd[k], 1'b1, 1'b0);
    if (FRAME == 9) step(1'b0, 1'b1, 1'b0);
    check("serr_new_dout", 32'(bus.dout), 32'hA5);

    // No sync after reset: samples are discarded.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'($urandom_range(1)), 1'b1, 1'b0);
      check("nosync_slot", 32'(bus.slot), 32'h0);
    end

    // Reset mid-frame at slot 6, then a fresh sync is required.
    send_frame(8'h3C, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, k == 0);
    check("pre_rst_slot", 32'(bus.slot), 32'h6);
    do_reset();
    send_frame(8'hFF, 1'b0, 1'b0);
    check("rst_nosync_dout", 32'(bus.dout), 32'h0);
    send_frame(8'h96, 1'b0, 1'b1);
    check("rst_resync_dout", 32'(bus.dout), 32'h96);

`ifdef TDM_DEMUX_PARITY_EN
    send_frame(8'h4D, 1'b1, 1'b1);
    check("par_bad_err",  32'(bus.par_err), 32'h1);
    check("par_bad_dout", 32'(bus.dout),    32'h4D);
    send_frame(8'h4D, 1'b0, 1'b1);
    check("par_ok_err",   32'(bus.par_err), 32'h0);
    check("par_ok_dout",  32'(bus.dout),    32'h4D);
`endif

    // Randomized traffic: gaps, occasional syncs, rare resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399) == 0) do_reset();
      else step(1'($urandom_range(1)), $urandom_range(9) < 7, $urandom_range(19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
